// File: rtl/sr_flag_sched_if.sv
// Requester-side command bus for sr_flag_sched: per-requester valid/op/index
// fields in, one-hot grant out.
interface sr_flag_sched_if #(
  parameter int NREQ = 4,
  parameter int IDXW = 3
);
  logic [NREQ-1:0]      req_valid;
  logic [2*NREQ-1:0]    req_op;
  logic [IDXW*NREQ-1:0] req_idx;
  logic [NREQ-1:0]      req_ready;

  modport master (
    output req_valid,
    output req_op,
    output req_idx,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_idx,
    output req_ready
  );
endinterface

// File: rtl/sr_flag_sched.sv
// Round-robin scheduler serialising set/reset/toggle commands from NREQ
// requesters into one-hot s/r pulses for a bank of NFF SR flops, with a q mirror.
module sr_flag_sched #(
  parameter int NREQ    = 4,
  parameter int NFF     = 8,
  parameter int IDXW    = 3,
  parameter int PULSE_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  sr_flag_sched_if.slave    req,
  output logic [NFF-1:0]    s_out,
  output logic [NFF-1:0]    r_out,
  output logic [NFF-1:0]    q,
  output logic              busy,
  output logic              err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDXW:0] NFF_L = (IDXW + 1)'(NFF);

  typedef enum logic {IDLE, PULSE} state_t;
  typedef enum logic [1:0] {OP_NOP, OP_RST, OP_SET, OP_TGL} op_t;

  state_t          state, state_n;
  logic [PW-1:0]   rr_ptr, rr_n;
  logic [3:0]      cnt, cnt_n;
  logic [NFF-1:0]  q_n, s_n, r_n;
  logic            busy_n, err_n;

  logic            gnt_found;
  logic [PW-1:0]   gnt_id;
  int unsigned     scan_i;
  op_t             sel_op;
  logic [IDXW-1:0] sel_idx;
  logic            idx_ok;
  logic            make_set;
  logic [NFF-1:0]  onehot;

  // Rotating priority scan starting at rr_ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan_i    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_i = (int'(rr_ptr) + k) % NREQ;
      if (!gnt_found && req.req_valid[scan_i]) begin
        gnt_found = 1'b1;
        gnt_id    = PW'(scan_i);
      end
    end
  end

  assign req.req_ready = (state == IDLE && !rst && gnt_found)
                         ? (NREQ'(1) << gnt_id) : '0;

  assign sel_op  = op_t'(req.req_op[2*int'(gnt_id) +: 2]);
  assign sel_idx = req.req_idx[IDXW*int'(gnt_id) +: IDXW];
  assign idx_ok  = {1'b0, sel_idx} < NFF_L;
  assign onehot  = NFF'(1) << sel_idx;

  always_comb begin
    state_n  = state;
    rr_n     = rr_ptr;
    cnt_n    = cnt;
    q_n      = q;
    s_n      = s_out;
    r_n      = r_out;
    busy_n   = busy;
    err_n    = err;
    make_set = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_found) begin
          rr_n = (gnt_id == PW'(NREQ - 1)) ? '0 : gnt_id + PW'(1);
          if (sel_op == OP_NOP || !idx_ok) begin
            err_n = 1'b1;
          end else begin
            // Toggle resolves against the mirror as it stands in the accept cycle.
            make_set = (sel_op == OP_SET) ||
                       (sel_op == OP_TGL && (q & onehot) == '0);
            q_n      = make_set ? (q | onehot) : (q & ~onehot);
            s_n      = make_set ? onehot : '0;
            r_n      = make_set ? '0 : onehot;
            busy_n   = 1'b1;
            cnt_n    = 4'(PULSE_W - 1);
            state_n  = PULSE;
          end
        end
      end
      PULSE: begin
        if (cnt != '0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          s_n     = '0;
          r_n     = '0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      cnt    <= '0;
      q      <= '0;
      s_out  <= '0;
      r_out  <= '0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_n;
      cnt    <= cnt_n;
      q      <= q_n;
      s_out  <= s_n;
      r_out  <= r_n;
      busy   <= busy_n;
      err    <= err_n;
    end
  end

endmodule

// File: tb/tb_sr_flag_sched.sv
// Self-checking bench for sr_flag_sched: directed vector table, reset-mid-pulse
// sequence and randomized traffic against a transaction-level reference model.
module tb_sr_flag_sched;

  localparam int NREQ    = 4;
  localparam int NFF     = 6;
  localparam int IDXW    = 3;
  localparam int PULSE_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NFF-1:0] s_out, r_out, q;
  logic busy, err;

  sr_flag_sched_if #(.NREQ(NREQ), .IDXW(IDXW)) bus ();

  sr_flag_sched #(.NREQ(NREQ), .NFF(NFF), .IDXW(IDXW), .PULSE_W(PULSE_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (bus),
    .s_out (s_out),
    .r_out (r_out),
    .q     (q),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: remaining pulse cycles, pulse kind/target, flop states.
  int             m_left;
  bit             m_set;
  int             m_idx;
  bit [NFF-1:0]   m_q;
  int             m_rr;
  bit             m_err;

  function automatic int m_grant(bit [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_rr + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_step(bit r, bit [NREQ-1:0] v, bit [2*NREQ-1:0] o,
                                     bit [IDXW*NREQ-1:0] x);
    int g, op, ix;
    if (r) begin
      m_left = 0; m_set = 0; m_idx = 0; m_q = '0; m_rr = 0; m_err = 0;
      return;
    end
    if (m_left > 0) begin
      m_left--;
      return;
    end
    g = m_grant(v);
    if (g < 0) return;
    op = int'(o[2*g +: 2]);
    ix = int'(x[IDXW*g +: IDXW]);
    if (op == 0 || ix >= NFF) begin
      m_err = 1;
    end else begin
      m_set = (op == 2) || (op == 3 && m_q[ix] == 1'b0);
      m_q[ix] = m_set;
      m_idx = ix;
      m_left = PULSE_W;
    end
    m_rr = (g + 1) % NREQ;
  endfunction

  task automatic apply(bit r, bit [NREQ-1:0] v, bit [2*NREQ-1:0] o, bit [IDXW*NREQ-1:0] x);
    @(posedge clk);
    #1;
    rst = r;
    bus.req_valid = v;
    bus.req_op    = o;
    bus.req_idx   = x;
    @(negedge clk);
  endtask

  task automatic check_inv();
    chk("inv_s_and_r", 32'((s_out & r_out) != '0), 32'd0);
    chk("inv_pulse_onehot", 32'($countones(s_out | r_out) > 1), 32'd0);
    chk("inv_ready_onehot", 32'($countones(bus.req_ready) > 1), 32'd0);
  endtask

  task automatic model_check(bit r, bit [NREQ-1:0] v);
    bit [NFF-1:0]  es, er;
    bit [NREQ-1:0] erdy;
    int g;
    es = '0; er = '0; erdy = '0;
    if (m_left > 0) begin
      if (m_set) es = NFF'(1) << m_idx;
      else       er = NFF'(1) << m_idx;
    end
    g = m_grant(v);
    if (!r && m_left == 0 && g >= 0) erdy = NREQ'(1) << g;
    chk("m_ready", 32'(bus.req_ready), 32'(erdy));
    chk("m_s_out", 32'(s_out), 32'(es));
    chk("m_r_out", 32'(r_out), 32'(er));
    chk("m_q",     32'(q),     32'(m_q));
    chk("m_busy",  32'(busy),  32'(m_left > 0));
    chk("m_err",   32'(err),   32'(m_err));
    check_inv();
  endtask

  task automatic run_model(bit r, bit [NREQ-1:0] v, bit [2*NREQ-1:0] o, bit [IDXW*NREQ-1:0] x);
    apply(r, v, o, x);
    model_check(r, v);
    model_step(r, v, o, x);
  endtask

  typedef struct {
    bit                 rst;
    bit [NREQ-1:0]      v;
    bit [2*NREQ-1:0]    o;
    bit [IDXW*NREQ-1:0] x;
    bit [NREQ-1:0]      e_rdy;
    bit [NFF-1:0]       e_s;
    bit [NFF-1:0]       e_r;
    bit [NFF-1:0]       e_q;
    bit                 e_busy;
    bit                 e_err;
  } vec_t;

  function automatic vec_t mk(bit r, bit [3:0] v, bit [7:0] o, bit [11:0] x, bit [3:0] erdy,
                              bit [5:0] es, bit [5:0] er, bit [5:0] eq, bit eb, bit ee);
    vec_t t;
    t.rst = r; t.v = v; t.o = o; t.x = x; t.e_rdy = erdy;
    t.e_s = es; t.e_r = er; t.e_q = eq; t.e_busy = eb; t.e_err = ee;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset, single set of idx 3 by req0
    tbl.push_back(mk(1, 4'b0000, 8'h00, 12'h000, 4'b0000, 6'h00, 6'h00, 6'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 8'h02, 12'h003, 4'b0001, 6'h00, 6'h00, 6'h00, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 4'b0000, 8'h00, 12'h000, 4'b0000, 6'h08, 6'h00, 6'h08, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 8'h00, 12'h000, 4'b0000, 6'h00, 6'h00, 6'h08, 0, 0));
    // req1 toggles idx 5 twice with valid held
    tbl.push_back(mk(0, 4'b0010, 8'h0C, 12'h028, 4'b0010, 6'h00, 6'h00, 6'h08, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 4'b0010, 8'h0C, 12'h028, 4'b0000, 6'h20, 6'h00, 6'h28, 1, 0));
    tbl.push_back(mk(0, 4'b0010, 8'h0C, 12'h028, 4'b0010, 6'h00, 6'h00, 6'h28, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 4'b0000, 8'h00, 12'h000, 4'b0000, 6'h00, 6'h20, 6'h08, 1, 0));
    // nop from req0, then out-of-range idx 7 and 6 from req2
    tbl.push_back(mk(0, 4'b0001, 8'h00, 12'h000, 4'b0001, 6'h00, 6'h00, 6'h08, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 8'h20, 12'h1C0, 4'b0100, 6'h00, 6'h00, 6'h08, 0, 1));
    tbl.push_back(mk(0, 4'b0100, 8'h20, 12'h180, 4'b0100, 6'h00, 6'h00, 6'h08, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 8'h00, 12'h000, 4'b0000, 6'h00, 6'h00, 6'h08, 0, 1));
    // fairness: all valid, req i sets idx i; pointer sits at 3 so order is 3,0,1,2
    tbl.push_back(mk(0, 4'b1111, 8'hAA, 12'h688, 4'b1000, 6'h00, 6'h00, 6'h08, 0, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 4'b1111, 8'hAA, 12'h688, 4'b0000, 6'h08, 6'h00, 6'h08, 1, 1));
    tbl.push_back(mk(0, 4'b1111, 8'hAA, 12'h688, 4'b0001, 6'h00, 6'h00, 6'h08, 0, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 4'b1111, 8'hAA, 12'h688, 4'b0000, 6'h01, 6'h00, 6'h09, 1, 1));
    tbl.push_back(mk(0, 4'b1111, 8'hAA, 12'h688, 4'b0010, 6'h00, 6'h00, 6'h09, 0, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 4'b1111, 8'hAA, 12'h688, 4'b0000, 6'h02, 6'h00, 6'h0B, 1, 1));
    tbl.push_back(mk(0, 4'b1111, 8'hAA, 12'h688, 4'b0100, 6'h00, 6'h00, 6'h0B, 0, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 4'b0000, 8'h00, 12'h000, 4'b0000, 6'h04, 6'h00, 6'h0F, 1, 1));
    tbl.push_back(mk(0, 4'b0000, 8'h00, 12'h000, 4'b0000, 6'h00, 6'h00, 6'h0F, 0, 1));

    bus.req_valid = '0; bus.req_op = '0; bus.req_idx = '0;
    apply(1, '0, '0, '0);
    model_step(1, '0, '0, '0);

    foreach (tbl[n]) begin
      apply(tbl[n].rst, tbl[n].v, tbl[n].o, tbl[n].x);
      chk($sformatf("t%0d_ready", n), 32'(bus.req_ready), 32'(tbl[n].e_rdy));
      chk($sformatf("t%0d_s_out", n), 32'(s_out), 32'(tbl[n].e_s));
      chk($sformatf("t%0d_r_out", n), 32'(r_out), 32'(tbl[n].e_r));
      chk($sformatf("t%0d_q", n),     32'(q),     32'(tbl[n].e_q));
      chk($sformatf("t%0d_busy", n),  32'(busy),  32'(tbl[n].e_busy));
      chk($sformatf("t%0d_err", n),   32'(err),   32'(tbl[n].e_err));
      check_inv();
      model_step(tbl[n].rst, tbl[n].v, tbl[n].o, tbl[n].x);
    end

    // Reset two cycles into a reset pulse on idx 2; pulse must be cut short.
    run_model(0, 4'b0010, 8'h0C, 12'h010);
    run_model(0, 4'b0000, 8'h00, 12'h000);
    run_model(1, 4'b0000, 8'h00, 12'h000);
    apply(0, 4'b1111, 8'hAA, 12'h688);
    chk("rstmid_s_out", 32'(s_out), 32'd0);
    chk("rstmid_r_out", 32'(r_out), 32'd0);
    chk("rstmid_q",     32'(q),     32'd0);
    chk("rstmid_busy",  32'(busy),  32'd0);
    chk("rstmid_err",   32'(err),   32'd0);
    chk("rstmid_grant", 32'(bus.req_ready), 32'b0001);
    model_check(0, 4'b1111);
    model_step(0, 4'b1111, 8'hAA, 12'h688);
    for (int i = 0; i < 12; i++) run_model(0, 4'b1111, 8'hAA, 12'h688);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      bit r;
      bit [NREQ-1:0] v;
      bit [2*NREQ-1:0] o;
      bit [IDXW*NREQ-1:0] x;
      r = ($urandom_range(0, 49) == 0);
      v = NREQ'($urandom);
      o = (2*NREQ)'($urandom);
      x = (IDXW*NREQ)'($urandom);
      run_model(r, v, o, x);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
